// File: rtl/keyencoder_radix.sv
// Radix-N keypad entry: synchronised press detection, digit shift register and valid/ready code hand-off.
// Press to output update takes SYNC_STAGES+1 edges; a presented code is held until code_ready.
module keyencoder_radix #(
    parameter int DIGITS      = 9,
    parameter int RADIX_BITS  = 1,
    parameter int SYNC_STAGES = 2,
    localparam int NK   = 2**RADIX_BITS,
    localparam int CW   = DIGITS*RADIX_BITS,
    localparam int CNTW = $clog2(DIGITS+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NK-1:0]   keypad,
    input  logic            bksp,
    input  logic            enter_key,
    input  logic            arm,
    input  logic            code_ready,
    output logic [CW-1:0]   keycode,
    output logic [CNTW-1:0] digit_count,
    output logic            code_valid,
    output logic            store_dig,
    output logic            key_err
);

    localparam int NL = NK + 2;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DIGITS);
    localparam logic [NL-1:0]   LINE_ONE = NL'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t          state;
    logic [NL-1:0]   raw_lines;
    logic [NL-1:0]   sync_q [SYNC_STAGES];
    logic [NL-1:0]   prev_q;
    logic [NL-1:0]   lines;
    logic            strobe;
    logic            one_hot;
    logic            is_dig;
    logic            is_bksp;
    logic [RADIX_BITS-1:0] dig_val;
    logic [CW-1:0]   shifted;

    assign raw_lines = {enter_key, bksp, keypad};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= raw_lines;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lines   = sync_q[SYNC_STAGES-1];
    // All lines must have been released before the next press counts.
    assign strobe  = (|lines) && !(|prev_q);
    assign one_hot = (|lines) && ((lines & (lines - LINE_ONE)) == '0);
    assign is_dig  = |lines[NK-1:0];
    assign is_bksp = lines[NK];

    always_comb begin
        dig_val = '0;
        for (int i = 0; i < NK; i++) begin
            if (lines[i]) begin
                dig_val = RADIX_BITS'(i);
            end
        end
    end

    // Shift-and-insert also covers the single-digit case, where the new digit replaces the code.
    assign shifted = (keycode << RADIX_BITS) | CW'(dig_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            keycode     <= '0;
            digit_count <= '0;
            code_valid  <= 1'b0;
            store_dig   <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            store_dig <= 1'b0;
            key_err   <= 1'b0;
            case (state)
                IDLE: begin
                    keycode     <= '0;
                    digit_count <= '0;
                    if (arm) begin
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!arm) begin
                        state       <= IDLE;
                        keycode     <= '0;
                        digit_count <= '0;
                    end else if (strobe) begin
                        if (!one_hot) begin
                            key_err <= 1'b1;
                        end else if (is_dig) begin
                            if (digit_count < CNT_MAX) begin
                                keycode     <= shifted;
                                digit_count <= digit_count + CNT_ONE;
                                store_dig   <= 1'b1;
                            end else begin
                                key_err <= 1'b1;
                            end
                        end else if (is_bksp) begin
                            if (digit_count != '0) begin
                                keycode     <= keycode >> RADIX_BITS;
                                digit_count <= digit_count - CNT_ONE;
                            end else begin
                                key_err <= 1'b1;
                            end
                        end else begin
                            if (digit_count != '0) begin
                                state      <= HOLD;
                                code_valid <= 1'b1;
                            end else begin
                                key_err <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    // arm is only consulted once the consumer has taken the code.
                    if (code_ready) begin
                        code_valid  <= 1'b0;
                        keycode     <= '0;
                        digit_count <= '0;
                        state       <= arm ? COLLECT : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keyencoder_radix.sv
// Directed bench: two instances (binary 9-digit, radix-4 4-digit with 3 sync stages) checked against a scoreboard.
module tb_keyencoder_radix;

    typedef struct packed {
        logic [8:0] kc;
        logic [3:0] cnt;
        logic       vld;
        logic       st;
        logic       er;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] keypad_a;
    logic       bksp_a, enter_a, arm_a, ready_a;
    logic [8:0] kc_a;
    logic [3:0] cnt_a;
    logic       vld_a, st_a, er_a;
    logic [3:0] keypad_b;
    logic       bksp_b, enter_b, arm_b, ready_b;
    logic [7:0] kc_b;
    logic [2:0] cnt_b;
    logic       vld_b, st_b, er_b;

    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    rec_t q_a[$];
    rec_t q_b[$];
    rec_t prev_a = '0;
    rec_t prev_b = '0;
    rec_t snap_a, snap_b, exp_a, exp_b;

    always #5 clk = ~clk;

    keyencoder_radix #(.DIGITS(9), .RADIX_BITS(1), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .keypad(keypad_a), .bksp(bksp_a), .enter_key(enter_a),
        .arm(arm_a), .code_ready(ready_a), .keycode(kc_a), .digit_count(cnt_a),
        .code_valid(vld_a), .store_dig(st_a), .key_err(er_a)
    );

    keyencoder_radix #(.DIGITS(4), .RADIX_BITS(2), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .rst(rst), .keypad(keypad_b), .bksp(bksp_b), .enter_key(enter_b),
        .arm(arm_b), .code_ready(ready_b), .keycode(kc_b), .digit_count(cnt_b),
        .code_valid(vld_b), .store_dig(st_b), .key_err(er_b)
    );

    // Any pulse or change of code/count/valid is an output event and must match the next queued record.
    always @(negedge clk) begin
        if (mon_en) begin
            snap_a = {kc_a, cnt_a, vld_a, st_a, er_a};
            if (st_a || er_a || (snap_a[15:2] != prev_a[15:2])) begin
                checks++;
                assert (q_a.size() != 0) else begin
                    failures++;
                    $error("FAIL event_a unexpected observed=%h expected=none", snap_a);
                end
                if (q_a.size() != 0) begin
                    exp_a = q_a.pop_front();
                    checks++;
                    assert (snap_a === exp_a) else begin
                        failures++;
                        $error("FAIL event_a observed=%h expected=%h", snap_a, exp_a);
                    end
                end
            end
            prev_a = snap_a;

            snap_b = {1'b0, kc_b, 1'b0, cnt_b, vld_b, st_b, er_b};
            if (st_b || er_b || (snap_b[15:2] != prev_b[15:2])) begin
                checks++;
                assert (q_b.size() != 0) else begin
                    failures++;
                    $error("FAIL event_b unexpected observed=%h expected=none", snap_b);
                end
                if (q_b.size() != 0) begin
                    exp_b = q_b.pop_front();
                    checks++;
                    assert (snap_b === exp_b) else begin
                        failures++;
                        $error("FAIL event_b observed=%h expected=%h", snap_b, exp_b);
                    end
                end
            end
            prev_b = snap_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit b, input logic [8:0] kc, input logic [3:0] cnt,
                        input logic vld, input logic st, input logic er);
        rec_t r;
        r = {kc, cnt, vld, st, er};
        if (b) q_b.push_back(r);
        else   q_a.push_back(r);
    endtask

    // lines: [3:0] keypad (dut_a uses [1:0]), [4] backspace, [5] enter
    task automatic drive(input bit b, input logic [5:0] lines);
        if (b) begin
            keypad_b = lines[3:0];
            bksp_b   = lines[4];
            enter_b  = lines[5];
        end else begin
            keypad_a = lines[1:0];
            bksp_a   = lines[4];
            enter_a  = lines[5];
        end
    endtask

    task automatic press(input bit b, input logic [5:0] lines);
        @(negedge clk);
        drive(b, lines);
        repeat (4) @(negedge clk);
        drive(b, 6'd0);
        repeat (7) @(negedge clk);
    endtask

    task automatic key(input bit b, input int v);
        logic [5:0] l;
        l = 6'd1 << v;
        press(b, l);
    endtask

    initial begin
        rst = 1'b1;
        keypad_a = '0; bksp_a = 0; enter_a = 0; arm_a = 0; ready_a = 0;
        keypad_b = '0; bksp_b = 0; enter_b = 0; arm_b = 0; ready_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_kc_a", kc_a, 0);   chk("rst_cnt_a", cnt_a, 0); chk("rst_vld_a", vld_a, 0);
        chk("rst_st_a", st_a, 0);   chk("rst_er_a", er_a, 0);
        chk("rst_kc_b", kc_b, 0);   chk("rst_cnt_b", cnt_b, 0); chk("rst_vld_b", vld_b, 0);
        chk("rst_st_b", st_b, 0);   chk("rst_er_b", er_b, 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Binary entry 1,0,1,1 then enter, then hand-off.
        arm_a = 1'b1;
        repeat (2) @(negedge clk);
        push(0, 9'h001, 4'd1, 0, 1, 0); key(0, 1);
        push(0, 9'h002, 4'd2, 0, 1, 0); key(0, 0);
        push(0, 9'h005, 4'd3, 0, 1, 0); key(0, 1);
        push(0, 9'h00B, 4'd4, 0, 1, 0); key(0, 1);
        push(0, 9'h00B, 4'd4, 1, 0, 0); press(0, 6'b100000);
        chk("a_hold_vld", vld_a, 1);
        chk("a_hold_kc", kc_a, 9'h00B);
        push(0, 9'h000, 4'd0, 0, 0, 0);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("a_xfer_vld", vld_a, 0);
        chk("a_xfer_kc", kc_a, 0);

        // Radix-4: enter on empty code, then 3,1,2,bksp,0, enter.
        arm_b = 1'b1;
        repeat (2) @(negedge clk);
        push(1, 9'h000, 4'd0, 0, 0, 1); press(1, 6'b100000);
        chk("b_empty_enter_vld", vld_b, 0);
        push(1, 9'h003, 4'd1, 0, 1, 0); key(1, 3);
        push(1, 9'h00D, 4'd2, 0, 1, 0); key(1, 1);
        push(1, 9'h036, 4'd3, 0, 1, 0); key(1, 2);
        push(1, 9'h00D, 4'd2, 0, 0, 0); press(1, 6'b010000);
        push(1, 9'h034, 4'd3, 0, 1, 0); key(1, 0);
        push(1, 9'h034, 4'd3, 1, 0, 0); press(1, 6'b100000);

        // Held code: presses and arm drop must not disturb it.
        arm_b = 1'b0;
        key(1, 2);
        press(1, 6'b010000);
        press(1, 6'b100000);
        chk("b_hold_vld", vld_b, 1);
        chk("b_hold_kc", kc_b, 8'h34);
        chk("b_hold_cnt", cnt_b, 3);
        push(1, 9'h000, 4'd0, 0, 0, 0);
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_xfer_vld", vld_b, 0);

        // Disarmed: press has no effect.
        key(1, 1);
        chk("b_idle_cnt", cnt_b, 0);

        arm_b = 1'b1;
        push(1, 9'h001, 4'd1, 0, 1, 0); key(1, 1);
        push(1, 9'h006, 4'd2, 0, 1, 0); key(1, 2);
        push(1, 9'h006, 4'd2, 0, 0, 1); press(1, 6'b000011);
        // Key 1 held, key 0 added: only the first press counts.
        push(1, 9'h019, 4'd3, 0, 1, 0);
        @(negedge clk);
        keypad_b = 4'b0010;
        repeat (6) @(negedge clk);
        keypad_b = 4'b0011;
        repeat (6) @(negedge clk);
        keypad_b = 4'b0000;
        repeat (7) @(negedge clk);
        push(1, 9'h067, 4'd4, 0, 1, 0); key(1, 3);
        push(1, 9'h067, 4'd4, 0, 0, 1); key(1, 0);
        chk("b_full_kc", kc_b, 8'h67);
        chk("b_full_cnt", cnt_b, 4);
        push(1, 9'h019, 4'd3, 0, 0, 0); press(1, 6'b010000);

        // Drop arm mid-entry.
        push(1, 9'h000, 4'd0, 0, 0, 0);
        @(negedge clk);
        arm_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_disarm_kc", kc_b, 0);
        chk("b_disarm_cnt", cnt_b, 0);

        // Reset while holding a code.
        arm_b = 1'b1;
        push(1, 9'h002, 4'd1, 0, 1, 0); key(1, 2);
        push(1, 9'h002, 4'd1, 1, 0, 0); press(1, 6'b100000);
        push(1, 9'h000, 4'd0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("b_rst_vld", vld_b, 0);
        chk("b_rst_kc", kc_b, 0);
        repeat (2) @(negedge clk);

        push(1, 9'h000, 4'd0, 0, 0, 1); press(1, 6'b010000);

        // Latency: store_dig must rise exactly after the fourth edge and last one cycle.
        push(1, 9'h001, 4'd1, 0, 1, 0);
        @(negedge clk);
        keypad_b = 4'b0010;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat_store_e%0d", j), st_b, (j == 3) ? 1 : 0);
        end
        @(negedge clk);
        keypad_b = 4'b0000;
        repeat (8) @(negedge clk);

        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keyencoder_radix.md
# keyencoder_radix

Parametrised successor to the two-button binary key encoder. Synchronises a bank of one-hot digit buttons plus backspace and enter lines, and detects presses on rising edges. Shifts each accepted digit into a right-justified code register and presents the finished code to the register file through a valid/ready handshake. Sits between the physical keypad pins and the matrix operand/register-write logic.

## Interface
- DIGITS, 9: maximum digits per code; must be ≥ 1.
- RADIX_BITS, 1: bits per digit. Digit keys NK = 2**RADIX_BITS; RADIX_BITS=1 gives binary entry.
- SYNC_STAGES, 2: synchroniser flops per input line; must be ≥ 2.
- CW (localparam) = DIGITS*RADIX_BITS. CNTW (localparam) = $clog2(DIGITS+1).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- keypad  in  NK  asynchronous digit buttons; bit i high means digit value i.
- bksp  in  1  asynchronous backspace button.
- enter_key  in  1  asynchronous enter button.
- arm  in  1  synchronous enable from control FSM; entry accepted only while armed.
- code_ready  in  1  consumer accepts the presented code.
- keycode  out  CW  right-justified code, newest digit in [RADIX_BITS-1:0].
- digit_count  out  CNTW  digits currently held.
- code_valid  out  1  code complete; held until accepted.
- store_dig  out  1  one-cycle pulse per accepted digit.
- key_err  out  1  one-cycle pulse per rejected press.

## Operation
- Synchroniser: all NK+2 lines pass through SYNC_STAGES flops. A prev register holds the last synchronised vector.
- Strobe: (|sync) && !(|prev). A new press is recognised only after every line has been released.
- Press classification at strobe:
  - exactly one line high = valid press;
  - zero or more than one line high = key_err, no other effect.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - keycode=0, digit_count=0; presses ignored, no key_err.
  - arm=1 → COLLECT.
- COLLECT, when arm=0 → IDLE; keycode and count clear on the same edge. This has priority over any strobe.
- COLLECT, digit press v:
  - count<DIGITS: keycode={keycode[CW-RADIX_BITS-1:0], v}, count+1, store_dig.
  - count==DIGITS: key_err, no change.
- COLLECT, bksp:
  - count>0: keycode>>RADIX_BITS (zero-filled), count-1.
  - count==0: key_err.
- COLLECT, enter_key:
  - count>0: → HOLD, code_valid=1.
  - count==0: key_err, stay.
- HOLD:
  - keycode and count frozen; all presses ignored, no key_err.
  - code_ready=1 → transfer on that edge. Next state COLLECT if arm=1, else IDLE. keycode and count clear on the same edge.
  - arm=0 while code_valid is high does not drop the code. The handshake must complete first.
- With DIGITS=1 and RADIX_BITS=1, the block degenerates to single-bit entry; no shift source bits exist, so the new digit replaces keycode.

## Timing
- Reset values: keycode=0, digit_count=0, code_valid=0, store_dig=0, key_err=0, state=IDLE, all synchroniser/prev flops 0.
- Input latency: a line high before edge k appears in the last sync stage after edge k+SYNC_STAGES-1. Strobe is combinational in that cycle. keycode, digit_count, store_dig, key_err and the state change register at edge k+SYNC_STAGES (SYNC_STAGES+1 edges total).
- store_dig and key_err are high for exactly one cycle, aligned with the keycode/count update.
- code_valid rises the edge after enter is accepted. It falls on the edge where code_valid && code_ready is sampled. The code is taken on that edge.
- code_ready while code_valid=0 has no effect.
- Back-to-back codes: a press whose strobe lands in the cycle right after the transfer edge is processed normally in COLLECT.
- rst during any state returns all outputs to reset values on the next edge; any in-flight code is discarded.

## Test plan
- DIGITS=9, RADIX_BITS=1, arm=1: press 1,0,1,1 then enter → keycode=9'h00B, digit_count=4, store_dig pulses ×4, code_valid=1. code_ready=1 for one cycle → code_valid=0, keycode=0.
- DIGITS=4, RADIX_BITS=2: press 3,1,2, then bksp, then 0 → keycode=8'h34 (digits 3,1,0), digit_count=3. Hold code_ready=0 for 20 cycles while pressing keys → code_valid stays 1, keycode stays 8'h34, no store_dig.
- DIGITS=4, RADIX_BITS=2: five digit presses → fifth gives key_err, keycode holds first four, digit_count=4. Enter with count 0 after reset → key_err, code_valid stays 0.
- Press keypad[0] and keypad[1] simultaneously → key_err only. Hold key 1 without releasing and press key 0 → no strobe, no change. Press with arm=0 → no effect at all.
- Mid-entry (count=3), drop arm → IDLE, keycode=0. Mid-HOLD, assert rst → code_valid=0, all outputs at reset values next edge.
- Latency check at SYNC_STAGES=3: keypad[1] rises before edge k → store_dig high exactly after edge k+3, and high for a single cycle.
